// File: rtl/pulse_cfg_ctrl_if.sv
// UART byte link for the pulse configuration controller.
// Receive strobe in, response byte out with ready/valid.
interface pulse_cfg_ctrl_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       tx_ready;
   logic [7:0] tx_data;
   logic       tx_valid;

   modport master (
      output rx_data, rx_valid, tx_ready,
      input  tx_data, tx_valid
   );

   modport slave (
      input  rx_data, rx_valid, tx_ready,
      output tx_data, tx_valid
   );
endinterface

// File: rtl/pulse_cfg_ctrl.sv
// Framed serial register writes into shadow registers,
// committed to active pulse timing at sequence boundaries.
module pulse_cfg_ctrl #(
   parameter logic [7:0]  HDR        = 8'hA5,
   parameter int          TIMEOUT    = 100000,
   parameter logic [23:0] PERIOD_RST = 24'd1000,
   parameter logic [23:0] W1_RST     = 24'd10
) (
   input  logic            i_clk,
   input  logic            i_resetn,
   input  logic            i_cycle_end,
   pulse_cfg_ctrl_if.slave if_uart,
   output logic [23:0]     o_period,
   output logic [23:0]     o_p1_width,
   output logic [23:0]     o_p2_delay,
   output logic [23:0]     o_p2_width,
   output logic            o_run,
   output logic            o_cpmg,
   output logic            o_cfg_load
);

   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [7:0] ACK = 8'h06;
   localparam logic [7:0] NAK = 8'h15;

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_D2, S_D1, S_D0, S_CSUM
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [TW-1:0] r_tmo;
   logic [TW-1:0] w_tmo_nxt;
   logic          w_done;

   logic [7:0]    r_addr;
   logic [23:0]   r_data;
   logic          w_csum_ok;
   logic          w_addr_ok;
   logic          w_ack;
   logic          w_commit;
   logic          w_copy;

   logic [23:0]   r_sh_period;
   logic [23:0]   r_sh_p1w;
   logic [23:0]   r_sh_p2d;
   logic [23:0]   r_sh_p2w;
   logic [1:0]    r_sh_ctrl;

   logic [23:0]   r_period;
   logic [23:0]   r_p1w;
   logic [23:0]   r_p2d;
   logic [23:0]   r_p2w;
   logic [1:0]    r_ctrl;

   logic          r_pend;
   logic          r_copied;
   logic          r_cfg_load;
   logic          r_tx_valid;
   logic [7:0]    r_tx_data;

   // Frame parser state and inter-byte timeout counter.
   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         r_state <= S_IDLE;
         r_tmo   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_tmo   <= w_tmo_nxt;
      end
   end

   // Advance one state per byte; abort a stalled frame silently.
   always_comb begin
      w_state_nxt = r_state;
      w_tmo_nxt   = '0;
      w_done      = 1'b0;
      if (if_uart.rx_valid) begin
         unique case (r_state)
            S_IDLE: begin
               if (if_uart.rx_data == HDR) w_state_nxt = S_ADDR;
            end
            S_ADDR: w_state_nxt = S_D2;
            S_D2:   w_state_nxt = S_D1;
            S_D1:   w_state_nxt = S_D0;
            S_D0:   w_state_nxt = S_CSUM;
            S_CSUM: begin
               w_state_nxt = S_IDLE;
               w_done      = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end else if (r_state != S_IDLE) begin
         if (r_tmo == TMO_LAST) w_state_nxt = S_IDLE;
         else                   w_tmo_nxt   = r_tmo + 1'b1;
      end
   end

   // Capture address and data bytes of the frame in flight.
   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         r_addr <= '0;
         r_data <= '0;
      end else if (if_uart.rx_valid) begin
         unique case (r_state)
            S_ADDR:  r_addr         <= if_uart.rx_data;
            S_D2:    r_data[23:16]  <= if_uart.rx_data;
            S_D1:    r_data[15:8]   <= if_uart.rx_data;
            S_D0:    r_data[7:0]    <= if_uart.rx_data;
            default: ;
         endcase
      end
   end

   assign w_csum_ok = (r_addr ^ r_data[23:16] ^ r_data[15:8]
                       ^ r_data[7:0]) == if_uart.rx_data;

   // Legal addresses; a period below 2 is rejected.
   always_comb begin
      w_addr_ok = 1'b0;
      unique case (r_addr)
         8'h00:   w_addr_ok = (r_data >= 24'd2);
         8'h01,
         8'h02,
         8'h03,
         8'h04,
         8'h0F:   w_addr_ok = 1'b1;
         default: w_addr_ok = 1'b0;
      endcase
   end

   assign w_ack    = w_done && w_csum_ok && w_addr_ok;
   assign w_commit = w_ack && (r_addr == 8'h0F);
   assign w_copy   = r_pend && (!r_ctrl[0] || i_cycle_end);

   // Accepted writes land in the shadow set only.
   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         r_sh_period <= PERIOD_RST;
         r_sh_p1w    <= W1_RST;
         r_sh_p2d    <= '0;
         r_sh_p2w    <= '0;
         r_sh_ctrl   <= '0;
      end else if (w_ack) begin
         unique case (r_addr)
            8'h00:   r_sh_period <= r_data;
            8'h01:   r_sh_p1w    <= r_data;
            8'h02:   r_sh_p2d    <= r_data;
            8'h03:   r_sh_p2w    <= r_data;
            8'h04:   r_sh_ctrl   <= r_data[1:0];
            default: ;
         endcase
      end
   end

   // Whole shadow set moves to active in one edge.
   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         r_period <= PERIOD_RST;
         r_p1w    <= W1_RST;
         r_p2d    <= '0;
         r_p2w    <= '0;
         r_ctrl   <= '0;
      end else if (w_copy) begin
         r_period <= r_sh_period;
         r_p1w    <= r_sh_p1w;
         r_p2d    <= r_sh_p2d;
         r_p2w    <= r_sh_p2w;
         r_ctrl   <= r_sh_ctrl;
      end
   end

   // Pending commit; a fresh commit outranks a same-edge copy.
   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         r_pend     <= 1'b0;
         r_copied   <= 1'b0;
         r_cfg_load <= 1'b0;
      end else begin
         r_pend     <= w_commit || (r_pend && !w_copy);
         r_copied   <= w_copy;
         r_cfg_load <= r_copied;
      end
   end

   // Response byte; a newer response overwrites an unsent one.
   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         r_tx_valid <= 1'b0;
         r_tx_data  <= '0;
      end else if (w_done) begin
         r_tx_valid <= 1'b1;
         r_tx_data  <= w_ack ? ACK : NAK;
      end else if (r_tx_valid && if_uart.tx_ready) begin
         r_tx_valid <= 1'b0;
      end
   end

   assign if_uart.tx_valid = r_tx_valid;
   assign if_uart.tx_data  = r_tx_data;
   assign o_period         = r_period;
   assign o_p1_width       = r_p1w;
   assign o_p2_delay       = r_p2d;
   assign o_p2_width       = r_p2w;
   assign o_run            = r_ctrl[0];
   assign o_cpmg           = r_ctrl[1];
   assign o_cfg_load       = r_cfg_load;

endmodule

// File: tb/tb_pulse_cfg_ctrl.sv
// Bench for pulse_cfg_ctrl: frame-level reference model,
// per-cycle compare, directed scenarios then random traffic.
module tb_pulse_cfg_ctrl;

   localparam int TMO = 64;
   localparam logic [7:0] HDR = 8'hA5;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        cyc = 1'b0;
   logic [23:0] period, p1w, p2d, p2w;
   logic        run, cpmg, cfg_load;
   bit          rnd = 1'b0;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   pulse_cfg_ctrl_if u_if ();

   pulse_cfg_ctrl #(.TIMEOUT(TMO)) dut (
      .i_clk       (clk),
      .i_resetn    (rstn),
      .i_cycle_end (cyc),
      .if_uart     (u_if),
      .o_period    (period),
      .o_p1_width  (p1w),
      .o_p2_delay  (p2d),
      .o_p2_width  (p2w),
      .o_run       (run),
      .o_cpmg      (cpmg),
      .o_cfg_load  (cfg_load)
   );

   // Reference model: register files plus a byte list per frame.
   logic [23:0] m_sh [5];
   logic [23:0] m_act [5];
   logic        m_pend, m_copied, m_cfg, m_txv;
   logic [7:0]  m_txd;
   logic [7:0]  fq [$];
   int          gap;
   bit          m_started = 1'b0;
   logic        cp, cm, ok;
   logic [7:0]  fa;
   logic [23:0] fd;

   always @(posedge clk) begin
      if (!rstn) begin
         m_sh[0] = 24'd1000;
         m_sh[1] = 24'd10;
         m_sh[2] = 24'd0;
         m_sh[3] = 24'd0;
         m_sh[4] = 24'd0;
         m_act = m_sh;
         m_pend = 0; m_copied = 0; m_cfg = 0;
         m_txv = 0; m_txd = 8'h00;
         fq.delete();
         gap = 0;
      end else begin
         cp = m_pend && (m_act[4][0] == 1'b0 || cyc);
         cm = 1'b0;
         m_cfg = m_copied;
         m_copied = cp;
         if (cp) m_act = m_sh;
         if (m_txv && u_if.tx_ready) m_txv = 1'b0;
         if (u_if.rx_valid) begin
            gap = 0;
            if (fq.size() != 0 || u_if.rx_data == HDR)
               fq.push_back(u_if.rx_data);
            if (fq.size() == 6) begin
               fa = fq[1];
               fd = {fq[2], fq[3], fq[4]};
               ok = (fq[5] == (fq[1] ^ fq[2] ^ fq[3] ^ fq[4]));
               if (fa == 8'd0) ok = ok && (fd >= 24'd2);
               else if (!(fa <= 8'd4 || fa == 8'h0F)) ok = 1'b0;
               if (ok) begin
                  if (fa == 8'h0F) cm = 1'b1;
                  else if (fa == 8'd4) m_sh[4] = {22'd0, fd[1:0]};
                  else m_sh[fa[2:0]] = fd;
               end
               m_txv = 1'b1;
               m_txd = ok ? 8'h06 : 8'h15;
               fq.delete();
            end
         end else if (fq.size() != 0) begin
            gap++;
            if (gap >= TMO) begin
               fq.delete();
               gap = 0;
            end
         end
         m_pend = cm || (m_pend && !cp);
      end
      m_started = 1'b1;
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (m_started) begin
         n_chk++;
         if ({u_if.tx_valid, u_if.tx_data, period, p1w, p2d, p2w,
              run, cpmg, cfg_load} ===
             {m_txv, m_txd, m_act[0], m_act[1], m_act[2], m_act[3],
              m_act[4][0], m_act[4][1], m_cfg})
            n_pass++;
         else
            $display("FAIL cycle t=%0t got txv=%b txd=%h per=%0d p1=%0d p2d=%0d p2w=%0d run=%b cpmg=%b ld=%b required txv=%b txd=%h per=%0d p1=%0d p2d=%0d p2w=%0d run=%b cpmg=%b ld=%b",
                     $time, u_if.tx_valid, u_if.tx_data, period, p1w,
                     p2d, p2w, run, cpmg, cfg_load, m_txv, m_txd,
                     m_act[0], m_act[1], m_act[2], m_act[3],
                     m_act[4][0], m_act[4][1], m_cfg);
      end
   end

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h required %0h", nm, got, exp);
   endtask

   task automatic tick();
      @(negedge clk);
      if (rnd) begin
         cyc = ($urandom % 8 == 0);
         u_if.tx_ready = $urandom % 2;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int maxgap);
      repeat ($urandom_range(maxgap, 0)) tick();
      u_if.rx_valid = 1'b1;
      u_if.rx_data = b;
      tick();
      u_if.rx_valid = 1'b0;
      u_if.rx_data = $urandom;
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [23:0] d,
                             input bit bad, input int maxgap);
      logic [7:0] cs;
      cs = a ^ d[23:16] ^ d[15:8] ^ d[7:0];
      if (bad) cs = ~cs;
      send_byte(HDR, maxgap);
      send_byte(a, maxgap);
      send_byte(d[23:16], maxgap);
      send_byte(d[15:8], maxgap);
      send_byte(d[7:0], maxgap);
      send_byte(cs, maxgap);
   endtask

   initial begin
      logic [7:0]  a;
      logic [23:0] d;
      int          k;
      u_if.rx_valid = 1'b0;
      u_if.rx_data = 8'h00;
      u_if.tx_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_period", {8'd0, period}, 32'd1000);
      chk("rst_p1w", {8'd0, p1w}, 32'd10);
      chk("rst_run", {31'd0, run}, 32'd0);
      chk("rst_txv", {31'd0, u_if.tx_valid}, 32'd0);
      rstn = 1'b1;
      tick();

      // Immediate commit with run=0.
      send_frame(8'h00, 24'h0007D0, 0, 0);
      chk("ack_period", {24'd0, u_if.tx_data}, 32'h06);
      send_frame(8'h0F, 24'h000000, 0, 0);
      chk("ack_commit", {24'd0, u_if.tx_data}, 32'h06);
      chk("per_before", {8'd0, period}, 32'd1000);
      tick();
      chk("per_after", {8'd0, period}, 32'd2000);
      chk("ld_early", {31'd0, cfg_load}, 32'd0);
      tick();
      chk("ld_pulse", {31'd0, cfg_load}, 32'd1);
      tick();
      chk("ld_end", {31'd0, cfg_load}, 32'd0);

      // Bad checksum, bad address, illegal period.
      send_frame(8'h01, 24'h000005, 1, 0);
      chk("nak_csum", {24'd0, u_if.tx_data}, 32'h15);
      send_frame(8'h0F, 24'h0, 0, 0);
      tick();
      chk("p1w_kept", {8'd0, p1w}, 32'd10);
      send_frame(8'h07, 24'h000001, 0, 0);
      chk("nak_addr", {24'd0, u_if.tx_data}, 32'h15);
      send_frame(8'h00, 24'h000001, 0, 0);
      chk("nak_per1", {24'd0, u_if.tx_data}, 32'h15);

      // Deferred commit with run=1.
      send_frame(8'h04, 24'h000001, 0, 0);
      send_frame(8'h0F, 24'h0, 0, 0);
      tick();
      chk("run_on", {31'd0, run}, 32'd1);
      send_frame(8'h03, 24'd500, 0, 0);
      send_frame(8'h0F, 24'h0, 0, 0);
      repeat (5) tick();
      chk("p2w_held", {8'd0, p2w}, 32'd0);
      cyc = 1'b1;
      tick();
      cyc = 1'b0;
      chk("p2w_upd", {8'd0, p2w}, 32'd500);
      tick();
      chk("ld_defer", {31'd0, cfg_load}, 32'd1);
      cyc = 1'b1;
      tick();
      cyc = 1'b0;
      tick();
      chk("ld_none", {31'd0, cfg_load}, 32'd0);

      // Partial frame times out silently.
      send_byte(HDR, 0);
      send_byte(8'h02, 0);
      repeat (3 * TMO) tick();
      chk("tmo_quiet", {31'd0, u_if.tx_valid}, 32'd0);
      send_frame(8'h01, 24'd20, 0, 0);
      chk("tmo_ack", {23'd0, u_if.tx_valid, u_if.tx_data}, 32'h106);

      // Back-pressure: latest response wins, single transfer.
      u_if.tx_ready = 1'b0;
      send_frame(8'h02, 24'd5, 0, 0);
      send_frame(8'h02, 24'd6, 1, 0);
      tick();
      chk("bp_hold", {23'd0, u_if.tx_valid, u_if.tx_data}, 32'h115);
      u_if.tx_ready = 1'b1;
      tick();
      chk("bp_done", {31'd0, u_if.tx_valid}, 32'd0);

      // Random traffic.
      rnd = 1'b1;
      for (int i = 0; i < 400; i++) begin
         k = $urandom % 10;
         case (k)
            0, 1:    a = 8'h00;
            2:       a = 8'h01;
            3:       a = 8'h02;
            4:       a = 8'h03;
            5, 6:    a = 8'h04;
            7, 8:    a = 8'h0F;
            default: a = $urandom;
         endcase
         d = $urandom;
         if (a == 8'h00 && $urandom % 4 == 0) d = $urandom % 3;
         if ($urandom % 10 == 0) send_byte($urandom, 2);
         if ($urandom % 60 == 0) begin
            send_byte(HDR, 1);
            send_byte(a, 1);
            repeat (2 * TMO) tick();
         end else if ($urandom % 80 == 0) begin
            send_byte(HDR, 1);
            send_byte(a, 1);
            rstn = 1'b0;
            tick();
            tick();
            rstn = 1'b1;
         end else begin
            send_frame(a, d, ($urandom % 8 == 0), 3);
         end
      end
      rnd = 1'b0;
      cyc = 1'b0;
      repeat (4) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pulse_cfg_ctrl.md
# pulse_cfg_ctrl

Serial-command configuration controller for the pulse generator. Parses framed register writes arriving as bytes from the UART receiver and holds them in shadow registers. Commits shadow values to the active pulse-timing registers only at a pulse-sequence boundary, so Pulse/P2 never see a half-updated configuration. Returns a one-byte ACK/NAK per frame to the UART transmitter.

## Interface
- `HDR`, 8'hA5: frame header byte.
- `TIMEOUT`, 100000: max clk cycles between bytes of one frame before abort.
- `PERIOD_RST`, 24'd1000: reset value of active/shadow period.
- `W1_RST`, 24'd10: reset value of pulse-1 width; all other registers reset to 0.
- `clk`  in  1  system clock; all logic on rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `rx_data`  in  8  received byte, valid when `rx_valid`.
- `rx_valid`  in  1  one-cycle strobe per received byte.
- `cycle_end`  in  1  one-cycle strobe from pulse generator at end of each sequence period.
- `tx_ready`  in  1  UART TX can accept a byte.
- `tx_data`  out  8  response byte (8'h06 ACK, 8'h15 NAK).
- `tx_valid`  out  1  response pending; held until `tx_ready`.
- `period`, `p1_width`, `p2_delay`, `p2_width`  out  24 each  active timing registers.
- `run`  out  1  active control bit 0: generator enable.
- `cpmg`  out  1  active control bit 1: multi-pulse mode.
- `cfg_load`  out  1  one-cycle strobe in the cycle after active registers change.

## Operation
- Frame: HDR, ADDR, D[23:16], D[15:8], D[7:0], CSUM; CSUM = ADDR ^ D2 ^ D1 ^ D0.
- FSM states: IDLE, ADDR, D2, D1, D0, CSUM. Each advances on `rx_valid`. IDLE ignores any byte != HDR.
- In CSUM on `rx_valid`: good checksum and valid address -> action + ACK; otherwise NAK, no register change. Return to IDLE either way.
- Addresses: 0 period, 1 p1_width, 2 p2_delay, 3 p2_width, 4 control (D[1:0] used, rest ignored), 8'h0F commit (data ignored). Any other address -> NAK.
- Writes 0–4 update shadow only.
- Commit sets `commit_pending`.
  - If active `run`=0: copy shadow -> active on the next clk.
  - Else: copy on the next `cycle_end`.
  - Copy clears `commit_pending`.
- Commit while already pending: ACK, stays pending; the later copy uses the latest shadow values.
- Shadow writes after commit but before copy are included in that copy.
- Period write of 0 or 1: NAK. Minimum legal period is 2.
- Timeout: counter resets on every `rx_valid`. In non-IDLE states, reaching TIMEOUT cycles -> IDLE, no response.
- A new response while `tx_valid` is still high overwrites `tx_data`; `tx_valid` stays high.

## Timing
- Reset (`resetn`=0 at a clk edge):
  - state IDLE; all shadow and active registers to defaults (`run`=0, `cpmg`=0).
  - `commit_pending`=0, `tx_valid`=0, `tx_data`=0, `cfg_load`=0, timeout counter 0.
- Reset mid-frame discards the frame.
- Response: `tx_valid` rises 1 clk after the CSUM `rx_valid`. Cleared on the clk after `tx_valid && tx_ready`.
- Immediate commit (run=0): active updated 1 clk after the commit frame's CSUM byte; `cfg_load` high the following clk.
- Deferred commit: active updated at the edge where `cycle_end`=1; `cfg_load` high the next clk.
- `cycle_end` coinciding with the CSUM byte of a commit frame: that `cycle_end` is not used; wait for the next one.
- `cycle_end` with no pending commit: no effect.
- Commit setting `run`=0 takes effect at the boundary like any other field.

## Test plan
- Reset with `resetn`=0 -> `period`=1000, `p1_width`=10, `run`=0, `tx_valid`=0.
- Run=0; frames A5 00 00 07 D0 D7 then A5 0F 00 00 00 0F -> two ACKs (06). `period`=2000 one clk after the second CSUM. `cfg_load` pulses once.
- Run=1 active; write p2_width=500, then commit -> outputs unchanged until `cycle_end`, updated at that edge. Second `cycle_end` gives no further `cfg_load`.
- Bad checksum A5 01 00 00 05 00 -> NAK 15; shadow `p1_width` unchanged, verified by a later commit.
- Address 07 -> NAK. Period 000001 -> NAK.
- Send A5 02 then idle >100000 cycles, then a full valid frame -> no response to the partial frame; full frame ACKed.
- Hold `tx_ready`=0 across two frames -> `tx_valid` stays high with the latest response byte; one transfer after `tx_ready`.
